// File: rtl/fifo_pop_streamer_pkg.sv
// Shared definitions for the FIFO read-side streamer: FIFO geometry, word
// type, default burst length and the pop-admission rule.
package fifo_pkg;

  localparam int FIFO_W    = 32;
  localparam int FIFO_D    = 8;
  localparam int BURST_LEN = 4;

  typedef logic [FIFO_W-1:0] fifo_word_t;

  // A new pop is admitted when the words already committed (buffered plus
  // in flight) leave room in the 2-entry buffer, counting a slot that frees
  // up this cycle because the sink takes the head word.
  function automatic logic pop_allowed(input logic [1:0] pending, input logic fire);
    return (pending <= 2'd1) | ((pending == 2'd2) & fire);
  endfunction

endpackage

// File: rtl/fifo_pop_streamer_if.sv
// Bundle of the FIFO pop side and the downstream valid/ready stream.
// master: the streamer (drives pop_en and the stream outputs).
// slave:  the FIFO plus the stream sink seen as one environment.
interface fifo_pop_streamer_if #(
  parameter int fifo_w = fifo_pkg::FIFO_W
);

  logic              fifo_empty;
  logic [fifo_w-1:0] fifo_dout;
  logic              pop_en;
  logic              out_valid;
  logic              out_ready;
  logic [fifo_w-1:0] out_data;
  logic              out_last;

  modport master (
    input  fifo_empty,
    input  fifo_dout,
    input  out_ready,
    output pop_en,
    output out_valid,
    output out_data,
    output out_last
  );

  modport slave (
    output fifo_empty,
    output fifo_dout,
    output out_ready,
    input  pop_en,
    input  out_valid,
    input  out_data,
    input  out_last
  );

endinterface

// File: rtl/fifo_pop_streamer_stream_out_buf.sv
// Two-entry strict-order skid buffer that absorbs the FIFO read latency.
// A write and a read may land on the same edge at any occupancy; the caller
// guarantees it never writes into a full buffer without also reading.
module stream_out_buf import fifo_pkg::*; #(
  parameter int fifo_w = FIFO_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [fifo_w-1:0] wr_data,
  input  logic              rd_en,
  output logic [fifo_w-1:0] rd_data,
  output logic [1:0]        occ
);

  logic [fifo_w-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;

  // Pointer and occupancy bookkeeping; the only reset state in the buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (wr_en) wr_ptr <= ~wr_ptr;
      if (rd_en) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, wr_en} - {1'b0, rd_en};
    end
  end

  // Word storage; contents are only observed while occ is non-zero
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_pop_streamer.sv
// Read-side consumer for the synchronous FIFO. Pops words, absorbs the
// one-cycle read latency in a 2-entry buffer and presents them on a
// valid/ready stream at one word per cycle, flagging every burst_len-th
// word with out_last and counting accepted words.
module fifo_pop_streamer import fifo_pkg::*; #(
  parameter int fifo_w    = FIFO_W,
  parameter int burst_len = BURST_LEN,
  parameter int cnt_w     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  fifo_pop_streamer_if.master bus,
  output logic [cnt_w-1:0]    words_sent
);

  localparam int                BEAT_W   = (burst_len > 1) ? $clog2(burst_len) : 1;
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(burst_len - 1);

  logic              inflight;
  logic [1:0]        occ;
  logic [1:0]        pending;
  logic              fire;
  logic [BEAT_W-1:0] beat;
  logic [fifo_w-1:0] head;

  // ---- stage 0: pop request (combinational, includes out_ready -> pop_en) ----
  assign fire       = bus.out_valid & bus.out_ready;
  assign pending    = occ + {1'b0, inflight};
  assign bus.pop_en = ~rst & en & ~bus.fifo_empty & pop_allowed(pending, fire);

  // A pop issued at this edge delivers its word on fifo_dout next cycle
  always_ff @(posedge clk) begin
    if (rst) inflight <= 1'b0;
    else     inflight <= bus.pop_en;
  end

  // ---- stage 1: capture the popped word into the output buffer ----
  stream_out_buf #(
    .fifo_w (fifo_w)
  ) u_out_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (inflight),
    .wr_data (bus.fifo_dout),
    .rd_en   (fire),
    .rd_data (head),
    .occ     (occ)
  );

  // ---- stage 2: stream presentation ----
  assign bus.out_valid = (occ != 2'd0);
  assign bus.out_data  = bus.out_valid ? head : '0;
  assign bus.out_last  = bus.out_valid & (beat == BEAT_MAX);

  // Burst position and transfer count advance on every accepted word
  always_ff @(posedge clk) begin
    if (rst) begin
      beat       <= '0;
      words_sent <= '0;
    end else if (fire) begin
      beat       <= (beat == BEAT_MAX) ? '0 : beat + 1'b1;
      words_sent <= words_sent + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_pop_streamer.sv
// Bench for fifo_pop_streamer: a queue-based FIFO model feeds two DUTs
// (16-bit and 4-bit word counters) in lockstep; accepted words are logged
// and compared against an in-order reference built from the pushed words.
module tb_fifo_pop_streamer;
  import fifo_pkg::*;

  localparam int BL = BURST_LEN;

  typedef struct packed {
    logic [31:0] d;
    logic        last;
    logic [15:0] ws;
    logic [3:0]  ws4;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       out_ready = 1'b0;
  logic       fifo_empty = 1'b1;
  fifo_word_t fifo_dout = '0;
  logic       push_req = 1'b0;
  fifo_word_t push_data = '0;
  logic [15:0] words_sent;
  logic [3:0]  words_sent4;

  fifo_word_t fifo_q[$];
  fifo_word_t model_q[$];
  rec_t       obs_q[$];
  int         obs_cyc[$];
  int model_cnt = 0;
  int pop_cnt = 0;
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  fifo_pop_streamer_if #(.fifo_w(FIFO_W)) bus0 ();
  fifo_pop_streamer_if #(.fifo_w(FIFO_W)) bus1 ();

  assign bus0.fifo_empty = fifo_empty;
  assign bus0.fifo_dout  = fifo_dout;
  assign bus0.out_ready  = out_ready;
  assign bus1.fifo_empty = fifo_empty;
  assign bus1.fifo_dout  = fifo_dout;
  assign bus1.out_ready  = out_ready;

  fifo_pop_streamer #(.fifo_w(FIFO_W), .burst_len(BL), .cnt_w(16)) dut (
    .clk(clk), .rst(rst), .en(en), .bus(bus0), .words_sent(words_sent)
  );

  fifo_pop_streamer #(.fifo_w(FIFO_W), .burst_len(BL), .cnt_w(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .bus(bus1), .words_sent(words_sent4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // FIFO model: pop visible on fifo_dout the cycle after pop_en is sampled
  always @(posedge clk) begin
    if (rst) begin
      fifo_q.delete();
      fifo_empty <= 1'b1;
    end else begin
      if (bus0.pop_en && fifo_q.size() != 0) begin
        fifo_dout <= fifo_q.pop_front();
        pop_cnt++;
      end
      if (push_req) fifo_q.push_back(push_data);
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  // Log every accepted word, sampled away from the active edge
  always @(negedge clk) begin
    if (!rst && bus0.out_valid && bus0.out_ready) begin
      obs_q.push_back({bus0.out_data, bus0.out_last, words_sent, words_sent4});
      obs_cyc.push_back(cyc);
    end
  end

  // Reference: words leave in push order; the n-th word since reset is last
  // when n mod BL == BL-1, and the counters read n before it is accepted.
  function automatic rec_t model_next();
    rec_t e;
    e.d    = (model_q.size() != 0) ? model_q.pop_front() : 32'hxxxxxxxx;
    e.last = ((model_cnt % BL) == BL - 1);
    e.ws   = 16'(model_cnt);
    e.ws4  = 4'(model_cnt);
    model_cnt++;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; out_ready = 1'b0; push_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    model_q.delete(); obs_q.delete(); obs_cyc.delete();
    model_cnt = 0;
  endtask

  task automatic push_word(input fifo_word_t w);
    push_req = 1'b1; push_data = w;
    model_q.push_back(w);
    tick();
    push_req = 1'b0;
  endtask

  task automatic wait_obs(input int n);
    for (int c = 0; c < 200 && obs_q.size() < n; c++) tick();
  endtask

  task automatic test_reset();
    do_reset();
    en = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (bus0.pop_en !== 1'b0) begin failures++; $display("FAIL rst_pop_en got=%b exp=0", bus0.pop_en); end
    checks++; if (bus0.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", bus0.out_valid); end
    checks++; if (bus0.out_data !== 32'h0) begin failures++; $display("FAIL rst_out_data got=%h exp=0", bus0.out_data); end
    checks++; if (bus0.out_last !== 1'b0) begin failures++; $display("FAIL rst_out_last got=%b exp=0", bus0.out_last); end
    checks++; if (words_sent !== 16'd0) begin failures++; $display("FAIL rst_words_sent got=%0d exp=0", words_sent); end
    checks++; if (words_sent4 !== 4'd0) begin failures++; $display("FAIL rst_words_sent4 got=%0d exp=0", words_sent4); end
  endtask

  task automatic test_stream();
    rec_t r, e; int n;
    en = 1'b1; out_ready = 1'b1;
    push_word(32'hA1A1A1A1); push_word(32'hB2B2B2B2); push_word(32'hC3C3C3C3);
    wait_obs(3);
    n = obs_q.size();
    checks++; if (n != 3) begin failures++; $display("FAIL t1_fires got=%0d exp=3", n); end
    for (int i = 0; i < n; i++) begin
      r = obs_q.pop_front(); e = model_next();
      checks++; if (r !== e) begin failures++; $display("FAIL t1_word%0d got=%h exp=%h", i, r, e); end
    end
    obs_cyc.delete();
    tick();
    checks++; if (words_sent !== 16'd3) begin failures++; $display("FAIL t1_words_sent got=%0d exp=3", words_sent); end
  endtask

  task automatic test_back_to_back();
    rec_t r, e; int n, c, pc;
    do_reset();
    en = 1'b1; out_ready = 1'b1;
    push_word(32'hD4D4D4D4); push_word(32'hE5E5E5E5); push_word(32'hF6F6F6F6); push_word(32'h07070707);
    wait_obs(4);
    n = obs_q.size(); pc = 0;
    checks++; if (n != 4) begin failures++; $display("FAIL t2_fires got=%0d exp=4", n); end
    for (int i = 0; i < n; i++) begin
      r = obs_q.pop_front(); c = obs_cyc.pop_front(); e = model_next();
      checks++; if (r !== e) begin failures++; $display("FAIL t2_word%0d got=%h exp=%h", i, r, e); end
      if (i > 0) begin
        checks++; if (c != pc + 1) begin failures++; $display("FAIL t2_gap%0d got=%0d exp=%0d", i, c, pc + 1); end
      end
      pc = c;
    end
  endtask

  task automatic test_backpressure();
    rec_t r, e; int n, c, pc, p0; logic bad; fifo_word_t first, w;
    en = 1'b1; out_ready = 1'b0; p0 = pop_cnt; bad = 1'b0; first = '0;
    for (int i = 0; i < 5; i++) begin
      w = $urandom;
      if (i == 0) first = w;
      push_word(w);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus0.out_valid && bus0.out_data !== first) bad = 1'b1;
    end
    checks++; if (pop_cnt - p0 != 2) begin failures++; $display("FAIL t3_pops got=%0d exp=2", pop_cnt - p0); end
    checks++; if (fifo_q.size() != 3) begin failures++; $display("FAIL t3_fifo_level got=%0d exp=3", fifo_q.size()); end
    checks++; if (bus0.pop_en !== 1'b0) begin failures++; $display("FAIL t3_pop_en got=%b exp=0", bus0.pop_en); end
    checks++; if (bus0.out_valid !== 1'b1 || bus0.out_data !== first) begin failures++; $display("FAIL t3_head got=%b/%h exp=1/%h", bus0.out_valid, bus0.out_data, first); end
    checks++; if (bad !== 1'b0) begin failures++; $display("FAIL t3_stable got=%b exp=0", bad); end
    out_ready = 1'b1;
    wait_obs(5);
    n = obs_q.size(); pc = 0;
    checks++; if (n != 5) begin failures++; $display("FAIL t3_fires got=%0d exp=5", n); end
    for (int i = 0; i < n; i++) begin
      r = obs_q.pop_front(); c = obs_cyc.pop_front(); e = model_next();
      checks++; if (r !== e) begin failures++; $display("FAIL t3_word%0d got=%h exp=%h", i, r, e); end
      if (i > 0) begin
        checks++; if (c != pc + 1) begin failures++; $display("FAIL t3_gap%0d got=%0d exp=%0d", i, c, pc + 1); end
      end
      pc = c;
    end
  endtask

  task automatic test_en_drop();
    rec_t r, e; int n, p0; logic bad;
    en = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_word($urandom);
    tick(); tick();
    checks++; if (bus0.pop_en !== 1'b0) begin failures++; $display("FAIL t4_idle_pop_en got=%b exp=0", bus0.pop_en); end
    p0 = pop_cnt;
    en = 1'b1;
    #1;
    checks++; if (bus0.pop_en !== 1'b1) begin failures++; $display("FAIL t4_pop_en got=%b exp=1", bus0.pop_en); end
    tick();
    en = 1'b0; bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (bus0.pop_en !== 1'b0) bad = 1'b1;
      tick();
    end
    checks++; if (bad !== 1'b0) begin failures++; $display("FAIL t4_no_pop got=%b exp=0", bad); end
    checks++; if (pop_cnt - p0 != 1) begin failures++; $display("FAIL t4_pops got=%0d exp=1", pop_cnt - p0); end
    checks++; if (fifo_q.size() != 3) begin failures++; $display("FAIL t4_fifo_level got=%0d exp=3", fifo_q.size()); end
    n = obs_q.size();
    checks++; if (n != 1) begin failures++; $display("FAIL t4_inflight_fires got=%0d exp=1", n); end
    for (int i = 0; i < n; i++) begin
      r = obs_q.pop_front(); e = model_next();
      checks++; if (r !== e) begin failures++; $display("FAIL t4_inflight_word got=%h exp=%h", r, e); end
    end
    en = 1'b1;
    wait_obs(3);
    n = obs_q.size();
    checks++; if (n != 3) begin failures++; $display("FAIL t4_resume_fires got=%0d exp=3", n); end
    for (int i = 0; i < n; i++) begin
      r = obs_q.pop_front(); e = model_next();
      checks++; if (r !== e) begin failures++; $display("FAIL t4_word%0d got=%h exp=%h", i, r, e); end
    end
    obs_cyc.delete();
  endtask

  task automatic test_mid_reset();
    rec_t r, e; int n, p0;
    en = 1'b1; out_ready = 1'b0; p0 = pop_cnt;
    for (int i = 0; i < 3; i++) push_word($urandom);
    for (int c = 0; c < 20 && pop_cnt - p0 < 2; c++) tick();
    checks++; if (bus0.out_valid !== 1'b1) begin failures++; $display("FAIL t5_pre_valid got=%b exp=1", bus0.out_valid); end
    rst = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (bus0.pop_en !== 1'b0) begin failures++; $display("FAIL t5_rst_pop_en got=%b exp=0", bus0.pop_en); end
    tick();
    rst = 1'b0;
    model_q.delete(); obs_q.delete(); obs_cyc.delete();
    model_cnt = 0;
    checks++; if (bus0.out_valid !== 1'b0) begin failures++; $display("FAIL t5_out_valid got=%b exp=0", bus0.out_valid); end
    checks++; if (words_sent !== 16'd0) begin failures++; $display("FAIL t5_words_sent got=%0d exp=0", words_sent); end
    tick(); tick(); tick();
    checks++; if (bus0.out_valid !== 1'b0 || obs_q.size() != 0) begin failures++; $display("FAIL t5_discard got=%b/%0d exp=0/0", bus0.out_valid, obs_q.size()); end
    push_word(32'h12345678);
    wait_obs(1);
    n = obs_q.size();
    checks++; if (n != 1) begin failures++; $display("FAIL t5_fires got=%0d exp=1", n); end
    for (int i = 0; i < n; i++) begin
      r = obs_q.pop_front(); e = model_next();
      checks++; if (r !== e) begin failures++; $display("FAIL t5_word got=%h exp=%h", r, e); end
    end
    obs_cyc.delete();
  endtask

  task automatic test_wrap();
    rec_t r, e; int n;
    do_reset();
    en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 17; i++) push_word($urandom);
    wait_obs(17);
    n = obs_q.size();
    checks++; if (n != 17) begin failures++; $display("FAIL t6_fires got=%0d exp=17", n); end
    for (int i = 0; i < n; i++) begin
      r = obs_q.pop_front(); e = model_next();
      checks++; if (r !== e) begin failures++; $display("FAIL t6_word%0d got=%h exp=%h", i, r, e); end
    end
    obs_cyc.delete();
    tick();
    checks++; if (words_sent !== 16'd17) begin failures++; $display("FAIL t6_words_sent got=%0d exp=17", words_sent); end
    checks++; if (words_sent4 !== 4'd1) begin failures++; $display("FAIL t6_words_sent4 got=%0d exp=1", words_sent4); end
    checks++;
    if ({bus1.pop_en, bus1.out_valid, bus1.out_last, bus1.out_data} !== 35'd0) begin
      failures++;
      $display("FAIL t6_narrow_idle got=%b/%b/%b/%h exp=0/0/0/0", bus1.pop_en, bus1.out_valid, bus1.out_last, bus1.out_data);
    end
  endtask

  task automatic test_random();
    rec_t r, e; int n, exp_n; logic hold; fifo_word_t held;
    do_reset();
    hold = 1'b0; held = '0;
    for (int k = 0; k < 400; k++) begin
      if (hold) begin
        checks++;
        if (bus0.out_valid !== 1'b1 || bus0.out_data !== held) begin
          failures++;
          $display("FAIL rnd_hold%0d got=%b/%h exp=1/%h", k, bus0.out_valid, bus0.out_data, held);
        end
      end
      en        = ($urandom_range(0, 7) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      if (fifo_q.size() < FIFO_D - 2 && $urandom_range(0, 1) == 1) begin
        push_req = 1'b1; push_data = $urandom;
        model_q.push_back(push_data);
      end else begin
        push_req = 1'b0;
      end
      hold = bus0.out_valid & ~out_ready;
      held = bus0.out_data;
      tick();
    end
    push_req = 1'b0; en = 1'b1; out_ready = 1'b1;
    exp_n = obs_q.size() + model_q.size() - obs_q.size();
    exp_n = model_q.size();
    wait_obs(exp_n);
    n = obs_q.size();
    checks++; if (n != exp_n) begin failures++; $display("FAIL rnd_fires got=%0d exp=%0d", n, exp_n); end
    for (int i = 0; i < n; i++) begin
      r = obs_q.pop_front(); e = model_next();
      checks++; if (r !== e) begin failures++; $display("FAIL rnd_word%0d got=%h exp=%h", i, r, e); end
    end
    obs_cyc.delete();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_back_to_back();
    test_backpressure();
    test_en_drop();
    test_mid_reset();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
